visitor_scan_ctrl: RTL and testbench

Upstream control stage of the bidirectional visitor counter. It watches the two doorway sensors, decodes entry/exit sequences with a direction FSM, and keeps a saturating 4-digit BCD occupancy count. It time-multiplexes that count onto a single digit bus for the display. `digit_sel` and `digit_en` drive the select and data input of the downstream 1-to-4 digit demultiplexer directly.

---
 rtl/visitor_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_visitor_scan_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/visitor_scan_ctrl.sv
// Doorway direction decoder with a saturating 4-digit BCD occupancy count
// and a time-multiplexed digit bus for the downstream display demux.
module visitor_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sensor_a,
    input  logic        sensor_b,
    output logic [15:0] count_bcd,
    output logic [1:0]  digit_sel,
    output logic        digit_en,
    output logic [3:0]  bcd_digit,
    output logic        enter_pulse,
    output logic        exit_pulse,
    output logic        full,
    output logic        empty
);

    typedef enum logic [2:0] {
        IDLE, A1, AB_IN, B_IN, B1, AB_OUT, A_OUT, WAIT_CLR
    } state_t;

    localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [15:0]   MAX_BCD  = {4'(MAX_COUNT / 1000), 4'((MAX_COUNT / 100) % 10),
                                          4'((MAX_COUNT / 10) % 10), 4'(MAX_COUNT % 10)};

    logic          a_s1, a_s2, b_s1, b_s2;
    logic [1:0]    ab;
    state_t        state, state_nxt;
    logic          entry_evt, exit_evt;
    logic [PW-1:0] prescale;
    logic [1:0]    sel_nxt;
    logic [3:0]    en_vec;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {a_s1, a_s2, b_s1, b_s2} <= '0;
        else        {a_s1, a_s2, b_s1, b_s2} <= {sensor_a, a_s1, sensor_b, b_s1};
    end

    assign ab = {a_s2, b_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (ab == 2'b10) state_nxt = A1;
                      else if (ab == 2'b01) state_nxt = B1;
                      else if (ab == 2'b11) state_nxt = WAIT_CLR;
            A1:       if (ab == 2'b11) state_nxt = AB_IN;
                      else if (ab == 2'b00) state_nxt = IDLE;
                      else if (ab == 2'b01) state_nxt = WAIT_CLR;
            AB_IN:    if (ab == 2'b01) state_nxt = B_IN;
                      else if (ab == 2'b10) state_nxt = A1;
                      else if (ab == 2'b00) state_nxt = IDLE;
            B_IN:     if (ab == 2'b00) state_nxt = IDLE;
                      else if (ab == 2'b11) state_nxt = AB_IN;
                      else if (ab == 2'b10) state_nxt = WAIT_CLR;
            B1:       if (ab == 2'b11) state_nxt = AB_OUT;
                      else if (ab == 2'b00) state_nxt = IDLE;
                      else if (ab == 2'b10) state_nxt = WAIT_CLR;
            AB_OUT:   if (ab == 2'b10) state_nxt = A_OUT;
                      else if (ab == 2'b01) state_nxt = B1;
                      else if (ab == 2'b00) state_nxt = IDLE;
            A_OUT:    if (ab == 2'b00) state_nxt = IDLE;
                      else if (ab == 2'b11) state_nxt = AB_OUT;
                      else if (ab == 2'b01) state_nxt = WAIT_CLR;
            WAIT_CLR: if (ab == 2'b00) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        entry_evt = (state == B_IN)  && (ab == 2'b00);
        exit_evt  = (state == A_OUT) && (ab == 2'b00);
    end

    // Pulses still fire at the limits; only the count is clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_bcd   <= '0;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            enter_pulse <= entry_evt;
            exit_pulse  <= exit_evt;
            if (entry_evt && count_bcd != MAX_BCD)   count_bcd <= bcd_inc(count_bcd);
            else if (exit_evt && count_bcd != '0)    count_bcd <= bcd_dec(count_bcd);
        end
    end

    assign full  = (count_bcd == MAX_BCD);
    assign empty = (count_bcd == '0);

    // A digit is lit if it or any more significant digit is nonzero; units always lit.
    always_comb begin
        en_vec[3] = |count_bcd[15:12];
        en_vec[2] = en_vec[3] | (|count_bcd[11:8]);
        en_vec[1] = en_vec[2] | (|count_bcd[7:4]);
        en_vec[0] = 1'b1;
    end

    assign sel_nxt = (prescale == PRE_LAST) ? digit_sel + 2'd1 : digit_sel;

    // Select, data and enable register together so the demux never sees a mixed pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale  <= '0;
            digit_sel <= 2'd0;
            bcd_digit <= 4'd0;
            digit_en  <= 1'b1;
        end else begin
            prescale  <= (prescale == PRE_LAST) ? '0 : prescale + 1'b1;
            digit_sel <= sel_nxt;
            bcd_digit <= count_bcd[{sel_nxt, 2'b00} +: 4];
            digit_en  <= en_vec[sel_nxt];
        end
    end

endmodule

// File: tb/tb_visitor_scan_ctrl.sv
// Directed bench for visitor_scan_ctrl: walks, limits, BCD carry/borrow,
// scan blanking and asynchronous reset; a second instance saturates at 100.
module tb_visitor_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sensor_a = 1'b0;
    logic        sensor_b = 1'b0;
    logic [15:0] count_bcd, count_bcd2;
    logic [1:0]  digit_sel, digit_sel2;
    logic        digit_en, digit_en2;
    logic [3:0]  bcd_digit, bcd_digit2;
    logic        enter_pulse, enter_pulse2, exit_pulse, exit_pulse2;
    logic        full, full2, empty, empty2;

    int checks = 0;
    int failures = 0;
    int n_enter = 0, n_exit = 0, n_enter2 = 0;

    always #5 clk = ~clk;

    visitor_scan_ctrl #(.SCAN_DIV(4), .MAX_COUNT(9999)) dut (
        .clk(clk), .rst_n(rst_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .count_bcd(count_bcd), .digit_sel(digit_sel), .digit_en(digit_en),
        .bcd_digit(bcd_digit), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
        .full(full), .empty(empty)
    );

    visitor_scan_ctrl #(.SCAN_DIV(4), .MAX_COUNT(100)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .count_bcd(count_bcd2), .digit_sel(digit_sel2), .digit_en(digit_en2),
        .bcd_digit(bcd_digit2), .enter_pulse(enter_pulse2), .exit_pulse(exit_pulse2),
        .full(full2), .empty(empty2)
    );

    always @(negedge clk) begin
        if (enter_pulse)  n_enter++;
        if (exit_pulse)   n_exit++;
        if (enter_pulse2) n_enter2++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_walk(input int h);
        drive(1'b1, 1'b0, h); drive(1'b1, 1'b1, h); drive(1'b0, 1'b1, h); drive(1'b0, 1'b0, h);
    endtask

    task automatic exit_walk(input int h);
        drive(1'b0, 1'b1, h); drive(1'b1, 1'b1, h); drive(1'b1, 1'b0, h); drive(1'b0, 1'b0, h);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, count_bcd, 16'h0000);
        check({tag, "_sel"},   16'(digit_sel), 16'd0);
        check({tag, "_digit"}, 16'(bcd_digit), 16'd0);
        check({tag, "_en"},    16'(digit_en), 16'd1);
        check({tag, "_pulses"}, 16'({enter_pulse, exit_pulse}), 16'd0);
        check({tag, "_flags"}, 16'({empty, full}), 16'b10);
    endtask

    initial begin
        int e0, x0, e2;
        logic [1:0] prev;
        logic       found;
        logic [3:0] exp_d [4];
        logic       exp_e [4];
        exp_d = '{4'd2, 4'd4, 4'd0, 4'd0};
        exp_e = '{1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, 1'b0, 3);

        e0 = n_enter;
        enter_walk(5);
        drive(1'b0, 1'b0, 3);
        check("entry_pulses", 16'(n_enter - e0), 16'd1);
        check("entry_count", count_bcd, 16'h0001);
        check("entry_empty", 16'(empty), 16'd0);

        x0 = n_exit;
        exit_walk(5);
        drive(1'b0, 1'b0, 3);
        check("exit_pulses", 16'(n_exit - x0), 16'd1);
        check("exit_count", count_bcd, 16'h0000);
        check("exit_empty", 16'(empty), 16'd1);

        x0 = n_exit;
        exit_walk(5);
        drive(1'b0, 1'b0, 3);
        check("underflow_pulses", 16'(n_exit - x0), 16'd1);
        check("underflow_count", count_bcd, 16'h0000);

        e0 = n_enter;
        x0 = n_exit;
        drive(1'b1, 1'b0, 5); drive(1'b1, 1'b1, 5); drive(1'b1, 1'b0, 5); drive(1'b0, 1'b0, 5);
        drive(1'b1, 1'b0, 5); drive(1'b0, 1'b0, 5);
        drive(1'b1, 1'b1, 5); drive(1'b0, 1'b0, 5);
        check("abort_pulses", 16'((n_enter - e0) + (n_exit - x0)), 16'd0);
        check("abort_count", count_bcd, 16'h0000);

        repeat (42) enter_walk(1);
        drive(1'b0, 1'b0, 4);
        check("preload42_count", count_bcd, 16'h0042);

        prev = digit_sel;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (digit_sel == 2'd0 && prev == 2'd3) found = 1'b1;
            else prev = digit_sel;
        end
        check("scan_align", 16'(found), 16'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("scan_sel_%0d", i),   16'(digit_sel), 16'(i / 4));
            check($sformatf("scan_digit_%0d", i), 16'(bcd_digit), 16'(exp_d[i / 4]));
            check($sformatf("scan_en_%0d", i),    16'(digit_en),  16'(exp_e[i / 4]));
        end

        repeat (57) enter_walk(1);
        drive(1'b0, 1'b0, 4);
        check("preload99_count", count_bcd, 16'h0099);
        check("preload99_count_sat", count_bcd2, 16'h0099);

        enter_walk(1);
        drive(1'b0, 1'b0, 4);
        check("carry_count", count_bcd, 16'h0100);
        check("carry_full", 16'(full), 16'd0);
        check("sat_reach_count", count_bcd2, 16'h0100);
        check("sat_reach_full", 16'(full2), 16'd1);

        e2 = n_enter2;
        enter_walk(1);
        drive(1'b0, 1'b0, 4);
        check("sat_main_count", count_bcd, 16'h0101);
        check("sat_hold_count", count_bcd2, 16'h0100);
        check("sat_hold_full", 16'(full2), 16'd1);
        check("sat_pulse", 16'(n_enter2 - e2), 16'd1);

        exit_walk(1);
        exit_walk(1);
        drive(1'b0, 1'b0, 4);
        check("borrow_count", count_bcd, 16'h0099);
        check("borrow_count_sat", count_bcd2, 16'h0098);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, 1'b0, 3);
        repeat (5) enter_walk(1);
        drive(1'b0, 1'b0, 4);
        check("pre_midwalk_count", count_bcd, 16'h0005);

        drive(1'b1, 1'b0, 5);
        drive(1'b1, 1'b1, 5);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midwalk_reset");
        check("midwalk_reset_sat", count_bcd2, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        e0 = n_enter;
        x0 = n_exit;
        drive(1'b0, 1'b1, 5);
        drive(1'b0, 1'b0, 5);
        check("post_reset_pulses", 16'((n_enter - e0) + (n_exit - x0)), 16'd0);
        check("post_reset_count", count_bcd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
